// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, field offsets and stage-update actions for pipeline stage registers
package pipe_pkg;

    // EX/MEM boundary widths
    localparam int EXMEM_CTL_W  = 5;
    localparam int EXMEM_DATA_W = 101;

    // Default stall counter width
    localparam int DEFAULT_CNT_W = 16;

    // Control field bit offsets (write-back bits low, memory bits high)
    localparam int CTL_WB_REGWRITE  = 0;
    localparam int CTL_WB_MEMTOREG  = 1;
    localparam int CTL_MEM_BRANCH   = 2;
    localparam int CTL_MEM_READ     = 3;
    localparam int CTL_MEM_WRITE    = 4;

    // Payload field offsets (LSB positions and widths)
    localparam int PAY_DEST_LSB  = 0;
    localparam int PAY_DEST_W    = 4;
    localparam int PAY_RD2_LSB   = 4;
    localparam int PAY_RD2_W     = 32;
    localparam int PAY_ALU_LSB   = 36;
    localparam int PAY_ALU_W     = 32;
    localparam int PAY_ZERO_BIT  = 68;
    localparam int PAY_ADDER_LSB = 69;
    localparam int PAY_ADDER_W   = 32;

    // What the main entry does at the next active edge
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_LOAD_IN   = 2'd1,
        MAIN_LOAD_SKID = 2'd2,
        MAIN_CLEAR     = 2'd3
    } main_act_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+ctl+data storage entry with load and clear enables
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTL_W  = EXMEM_CTL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTL_W-1:0]  i_ctl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTL_W-1:0]  o_ctl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTL_W-1:0]  r_ctl;
    logic [DATA_W-1:0] r_data;

    // Clear drops the entry and zeroes its control but keeps the data; load captures a new entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctl   <= i_ctl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctl   = r_ctl;
    assign o_data  = r_data;

endmodule

// File: rtl/exmem_stage_reg.sv
// rtl/exmem_stage_reg.sv - handshaked pipeline stage register with skid entry, freeze, flush and stall counter
module exmem_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTL_W    = EXMEM_CTL_W,
    parameter int DATA_W   = EXMEM_DATA_W,
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int NEG_EDGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              w_clk;
    logic              w_main_valid;
    logic [CTL_W-1:0]  w_main_ctl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTL_W-1:0]  w_skid_ctl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_acc;
    logic              w_deq;
    main_act_e         w_main_act;
    logic              w_main_load;
    logic              w_main_clear;
    logic [CTL_W-1:0]  w_main_ctl_in;
    logic [DATA_W-1:0] w_main_data_in;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [CNT_W-1:0]  r_stall_cnt;

    // The whole stage runs on one edge; falling edge matches the legacy pipeline registers
    generate
        if (NEG_EDGE != 0) begin : g_neg_edge
            assign w_clk = ~clk;
        end else begin : g_pos_edge
            assign w_clk = clk;
        end
    endgenerate

    // Handshake: no acceptance while the skid is occupied, frozen, flushing or in reset
    assign in_ready  = !rst && !w_skid_valid && hit && !flush;
    assign out_valid = w_main_valid && hit;
    assign out_ctl   = w_main_valid ? w_main_ctl : '0;
    assign out_data  = w_main_data;
    assign w_acc     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;

    // Priority decision per edge: flush, then freeze (no change), then FIFO movement
    always_comb begin
        w_main_act   = MAIN_HOLD;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            w_main_act   = MAIN_CLEAR;
            w_skid_clear = 1'b1;
        end else if (hit) begin
            if (!w_main_valid) begin
                if (w_acc) w_main_act = MAIN_LOAD_IN;
            end else if (w_deq) begin
                if (w_skid_valid) begin
                    w_main_act   = MAIN_LOAD_SKID;
                    w_skid_clear = 1'b1;
                end else if (w_acc) begin
                    w_main_act = MAIN_LOAD_IN;
                end else begin
                    w_main_act = MAIN_CLEAR;
                end
            end else if (w_acc) begin
                w_skid_load = 1'b1;
            end
        end
    end

    assign w_main_load    = (w_main_act == MAIN_LOAD_IN) || (w_main_act == MAIN_LOAD_SKID);
    assign w_main_clear   = (w_main_act == MAIN_CLEAR);
    assign w_main_ctl_in  = (w_main_act == MAIN_LOAD_SKID) ? w_skid_ctl  : in_ctl;
    assign w_main_data_in = (w_main_act == MAIN_LOAD_SKID) ? w_skid_data : in_data;

    pipe_entry_reg #(
        .CTL_W  (CTL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (w_clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctl   (w_main_ctl_in),
        .i_data  (w_main_data_in),
        .o_valid (w_main_valid),
        .o_ctl   (w_main_ctl),
        .o_data  (w_main_data)
    );

    pipe_entry_reg #(
        .CTL_W  (CTL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (w_clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctl   (in_ctl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctl   (w_skid_ctl),
        .o_data  (w_skid_data)
    );

    // Count edges where a held entry could not leave (frozen or backpressured), saturating
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!flush && w_main_valid && (!hit || !out_ready)
                     && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// tb/tb_exmem_stage_reg.sv - self-checking bench for exmem_stage_reg against a queue reference model
module tb_exmem_stage_reg;
    import pipe_pkg::*;

    localparam int CW = EXMEM_CTL_W;
    localparam int DW = EXMEM_DATA_W;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          hit       = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctl    = '0;
    logic [DW-1:0] in_data   = '0;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctl;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall_cnt;

    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctl;
    logic [DW-1:0] b_out_data;
    logic [3:0]    b_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [CW-1:0] ctl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_last = '0;
    int unsigned   m_cnt  = 0;

    always #5 clk = ~clk;

    exmem_stage_reg #(.CTL_W(CW), .DATA_W(DW), .CNT_W(16), .NEG_EDGE(1)) u_dut (
        .clk(clk), .rst(rst), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctl(in_ctl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctl(a_out_ctl),
        .out_data(a_out_data), .stall_cnt(a_stall_cnt)
    );

    exmem_stage_reg #(.CTL_W(CW), .DATA_W(DW), .CNT_W(4), .NEG_EDGE(1)) u_sat (
        .clk(clk), .rst(rst), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctl(in_ctl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctl(b_out_ctl),
        .out_data(b_out_data), .stall_cnt(b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic observe(input string tag);
        int            n;
        logic          e_rdy, e_ov;
        logic [CW-1:0] e_ctl;
        logic [DW-1:0] e_data;
        int unsigned   e_a, e_b;
        n      = q.size();
        e_rdy  = !rst && (n < 2) && hit && !flush;
        e_ov   = (n > 0) && hit;
        e_ctl  = (n > 0) ? q[0].ctl  : '0;
        e_data = (n > 0) ? q[0].data : m_last;
        e_a    = (m_cnt > 65535) ? 65535 : m_cnt;
        e_b    = (m_cnt > 15) ? 15 : m_cnt;
        chk({tag, ".in_ready"},  a_in_ready,  e_rdy);
        chk({tag, ".out_valid"}, a_out_valid, e_ov);
        chk({tag, ".out_ctl"},   a_out_ctl,   e_ctl);
        chk({tag, ".out_data"},  a_out_data,  e_data);
        chk({tag, ".stall_cnt"}, a_stall_cnt, e_a);
        chk({tag, ".sat_valid"}, b_out_valid, e_ov);
        chk({tag, ".sat_data"},  b_out_data,  e_data);
        chk({tag, ".sat_cnt"},   b_stall_cnt, e_b);
    endtask

    // Reference: the stage is a FIFO of at most two entries; head is what the outputs show
    task automatic model_edge(output bit acc);
        bit   deq;
        ent_t e;
        acc = 1'b0;
        if (!rst) begin
            if (!flush && q.size() > 0 && (!hit || !out_ready)) m_cnt++;
            if (flush) begin
                q.delete();
            end else if (hit) begin
                deq = (q.size() > 0) && out_ready;
                acc = in_valid && (q.size() < 2);
                if (deq) void'(q.pop_front());
                if (acc) begin
                    e.ctl  = in_ctl;
                    e.data = in_data;
                    q.push_back(e);
                end
            end
            if (q.size() > 0) m_last = q[0].data;
        end
    endtask

    task automatic cycle(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input bit h, input bit f, input bit o, input string tag,
                         output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctl    = c;
        in_data   = d;
        hit       = h;
        flush     = f;
        out_ready = o;
        #1;
        observe(tag);
        model_edge(acc);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        bit acc;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        hit       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        q.delete();
        m_last = '0;
        m_cnt  = 0;
        #1;
        observe({tag, ".async"});
        @(negedge clk);
        @(posedge clk);
        #1;
        observe({tag, ".held"});
        rst = 1'b0;
        #1;
        observe({tag, ".release"});
        model_edge(acc);
        @(negedge clk);
    endtask

    initial begin
        bit            acc;
        bit            have;
        logic [CW-1:0] pc;
        logic [DW-1:0] pd;
        bit            v, h, f, o;

        // Power-on reset
        do_reset("por");

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) cycle(1'b1, 5'h1F, DW'(i), 1'b1, 1'b0, 1'b1, "stream", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "stream_drain", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "stream_idle", acc);

        // Backpressure fills the skid, then drains in order
        cycle(1'b1, 5'h03, DW'('hA), 1'b1, 1'b0, 1'b0, "bp_a", acc);
        cycle(1'b1, 5'h05, DW'('hB), 1'b1, 1'b0, 1'b0, "bp_b", acc);
        cycle(1'b1, 5'h09, DW'('hC), 1'b1, 1'b0, 1'b0, "bp_c_hold", acc);
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) cycle(1'b1, 5'h09, DW'('hC), 1'b1, 1'b0, 1'b1, "bp_release", acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "bp_drain", acc);

        // Freeze for five edges with one entry held
        cycle(1'b1, 5'h11, DW'('h3), 1'b1, 1'b0, 1'b0, "frz_load", acc);
        for (int i = 0; i < 5; i++) cycle(1'b1, 5'h12, DW'('h77), 1'b0, 1'b0, 1'b1, "frz", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "frz_deliver", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "frz_once", acc);

        // Flush with both entries full and a colliding input
        cycle(1'b1, 5'h1A, DW'('h11), 1'b1, 1'b0, 1'b0, "fl_a", acc);
        cycle(1'b1, 5'h1B, DW'('h12), 1'b1, 1'b0, 1'b0, "fl_b", acc);
        cycle(1'b1, 5'h1C, DW'('h13), 1'b0, 1'b1, 1'b1, "fl_flush", acc);
        cycle(1'b1, 5'h1D, DW'('h14), 1'b1, 1'b0, 1'b1, "fl_after", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "fl_deliver", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "fl_idle", acc);

        // Long stall saturates the narrow counter
        cycle(1'b1, 5'h07, DW'('h20), 1'b1, 1'b0, 1'b0, "sat_load", acc);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "sat", acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "sat_deliver", acc);

        // Reset asserted with both entries full
        cycle(1'b1, 5'h15, DW'('h31), 1'b1, 1'b0, 1'b0, "mr_a", acc);
        cycle(1'b1, 5'h16, DW'('h32), 1'b1, 1'b0, 1'b0, "mr_b", acc);
        do_reset("mid_rst");

        // Randomized traffic with upstream holding an offered entry until accepted
        have = 1'b0;
        pc   = '0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have) begin
                pc   = CW'($urandom);
                pd   = {$urandom, $urandom, $urandom, $urandom};
                have = 1'b1;
            end
            v = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 7) != 0);
            f = ($urandom_range(0, 31) == 0);
            o = ($urandom_range(0, 2) != 0);
            cycle(v, pc, pd, h, f, o, "rand", acc);
            if (acc || f) have = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exmem_stage_reg.md
Name: exmem_stage_reg

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register.
- Generic pipeline stage register: a control field (zeroed on bubble/flush) plus a data payload, with a valid/ready handshake, a 2-entry skid buffer, a global cache-hit freeze, synchronous flush and a saturating stall counter.
- Sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB); the core instantiates one per boundary with different widths.

Parameters:
- CTL_W, 5, width of control field (wb+mem control bits); forced to 0 whenever the stage holds a bubble.
- DATA_W, 101, width of data payload (adder out, alu out, zero flag, read data 2, dest reg, ...).
- CNT_W, 16, width of stall counter.
- NEG_EDGE, 1, 1 = update on falling clk edge (matches existing pipeline registers), 0 = rising edge.

Ports:
- clk  in  1  stage clock (edge selected by NEG_EDGE).
- rst  in  1  asynchronous, active-high reset.
- hit  in  1  memory-system hit; 0 freezes the whole stage.
- flush  in  1  synchronous flush; drops all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; in_ready = !skid_valid & hit & !flush.
- in_ctl  in  CTL_W  upstream control.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_valid = main_valid & hit.
- out_ready  in  1  downstream accepts.
- out_ctl  out  CTL_W  main control; 0 when !main_valid.
- out_data  out  DATA_W  main payload.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Storage: main entry (main_valid, main_ctl, main_data) drives the outputs; skid entry (skid_valid, skid_ctl, skid_data).
- Invariant: skid_valid implies main_valid.
- Reset (async, immediate): main_valid = skid_valid = 0; all ctl and data registers = 0; stall_cnt = 0. Therefore out_valid = 0, out_ctl = 0, out_data = 0, in_ready = 0 during reset and 1 after release.
- Transfer definitions: acc = in_valid & in_ready; deq = out_valid & out_ready.
- Latency: 1 clock edge from acc to out_valid when the stage is empty. Throughput 1 entry/cycle when out_ready is held high.
- Update, priority order (evaluated at each active edge):
  1. rst: reset state, as above.
  2. flush = 1: main_valid = skid_valid = 0; main_ctl = skid_ctl = 0; data registers hold. Input in the same cycle is dropped (in_ready = 0). Flush overrides hit.
  3. hit = 0: no state change at all. in_ready = 0 and out_valid = 0, so no transfer can occur.
  4. Otherwise:
     - main empty & acc: main <- input.
     - main full & deq & !skid_valid & acc: main <- input.
     - main full & deq & !skid_valid & !acc: main_valid = 0, main_ctl = 0.
     - main full & deq & skid_valid: main <- skid; skid_valid = 0, skid_ctl = 0. acc is impossible here because in_ready = 0.
     - main full & !deq & acc: skid <- input. in_ready drops on the next cycle.
     - main full & !deq & !acc: hold.
- Ordering is strict FIFO. No entry is lost or duplicated except by flush.
- out_ctl is 0 whenever main_valid = 0, so bubbles carry no write-back/memory control.
- stall_cnt: increments by 1 on each active edge where !rst & !flush & main_valid & (!hit | !out_ready). Saturates at 2^CNT_W-1 (no wrap). Cleared only by rst.
- Reset asserted mid-transfer: both entries are discarded immediately, without waiting for a clock edge.
- hit falling while the skid is full: both entries are held intact until hit returns.

Decomposition:
- Shared package (pipe_pkg): EXMEM_CTL_W = 5, EXMEM_DATA_W = 101, the bit-field offsets for wb/mem control and payload fields, and the default CNT_W.
- One natural sub-module, pipe_entry_reg: a single valid+ctl+data register with load/clear enables, instantiated twice (main, skid).
- The handshake/priority logic and stall_cnt stay in the top module.

Test Plan:
- Reset: assert rst mid-run with both entries full -> out_valid = 0, out_ctl = 0, stall_cnt = 0 immediately; after release in_ready = 1.
- Streaming: in_valid = 1 and out_ready = 1 for 8 cycles, data 0x1..0x8, ctl 0x1F -> out_data 0x1..0x8 in order, 1 edge latency, in_ready stays 1, stall_cnt = 0.
- Backpressure: drop out_ready with 0xA in main, send 0xB -> skid fills, in_ready = 0 and 0xC is held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC on consecutive cycles; stall_cnt equals the number of stalled edges.
- Freeze: hit = 0 for 5 cycles with main = 0x3 -> out_valid = 0, in_ready = 0, state unchanged, stall_cnt += 5. After hit = 1, 0x3 is delivered exactly once.
- Flush: both entries full, flush = 1 with in_valid = 1 -> next edge main_valid = skid_valid = 0, out_ctl = 0, input dropped; the following input is accepted normally.
- Saturation: CNT_W = 4, stall for 20 cycles -> stall_cnt sticks at 15.
